// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: in-order instruction-fetch responder (RAM read pipeline + credit-limited FWFT response FIFO) with flush and program-load write port
module imem_fetch_responder #(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_addr_o,
  input  logic        flush_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] mem [DEPTH];
  logic [64:0] fq [FIFO_DEPTH];
  logic [LATENCY-1:0] pv;
  logic pe [LATENCY];
  logic [31:0] pa [LATENCY];
  logic [31:0] pd [LATENCY];
  logic [PW:0] wp, rp;
  logic [CW-1:0] cnt;
  logic req_err, acc, pop, empty, unused_ok;
  assign unused_ok = ^wr_addr_i[1:0];
  assign req_err = |req_addr_i[1:0] || |req_addr_i[31:AW+2];
  assign req_ready_o = rst_n_i && !flush_i && cnt < CW'(FIFO_DEPTH);
  assign acc = req_valid_i && req_ready_o;
  assign empty = wp == rp;
  assign rsp_valid_o = !empty && !flush_i;
  assign pop = rsp_valid_o && rsp_ready_i;
  // Empty FIFO presents the reset-state response so outputs are defined without clearing storage.
  assign {rsp_err_o, rsp_addr_o, rsp_data_o} = empty ? {1'b0, 32'd0, NOP} : fq[rp[PW-1:0]];
  always_ff @(posedge sys_clk_i)
    if (wr_en_i && !(|wr_addr_i[31:AW+2])) mem[wr_addr_i[AW+1:2]] <= wr_data_i;
  always_ff @(posedge sys_clk_i)
    if (pv[LATENCY-1]) fq[wp[PW-1:0]] <= {pe[LATENCY-1], pa[LATENCY-1], pd[LATENCY-1]};
  // Stage 0 samples the RAM at the acceptance edge, so a same-edge write is not seen.
  always_ff @(posedge sys_clk_i) begin
    if (acc) begin
      pe[0] <= req_err;
      pa[0] <= req_addr_i;
      pd[0] <= req_err ? NOP : mem[req_addr_i[AW+1:2]];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pe[i] <= pe[i-1];
      pa[i] <= pa[i-1];
      pd[i] <= pd[i-1];
    end
  end
  always_ff @(posedge sys_clk_i or negedge rst_n_i)
    if (!rst_n_i || flush_i) begin
      pv <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      pv <= LATENCY'({pv, acc});
      wp <= wp + (PW+1)'(pv[LATENCY-1]);
      rp <= rp + (PW+1)'(pop);
      cnt <= cnt + CW'(acc) - CW'(pop);
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed self-checking bench for imem_fetch_responder
module tb_imem_fetch_responder;
  logic sys_clk_i = 0, rst_n_i = 0, req_valid_i = 0, rsp_ready_i = 0, flush_i = 0, wr_en_i = 0;
  logic [31:0] req_addr_i = 0, wr_addr_i = 0, wr_data_i = 0;
  logic req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_data_o, rsp_addr_o;
  int n_tests = 0, n_fail = 0, acc;
  imem_fetch_responder dut (
    .sys_clk_i(sys_clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .rsp_addr_o(rsp_addr_o), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
  );
  always #5 sys_clk_i = ~sys_clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_head(input string tag, input logic [31:0] d, input logic [31:0] a, input logic e);
    check({tag, ".valid"}, rsp_valid_o, 1);
    check({tag, ".data"}, rsp_data_o, d);
    check({tag, ".addr"}, rsp_addr_o, a);
    check({tag, ".err"}, rsp_err_o, e);
  endtask
  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge sys_clk_i);
      #1;
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en_i = 1;
    wr_addr_i = a;
    wr_data_i = d;
    step();
    wr_en_i = 0;
  endtask
  task automatic fill(output int n);
    logic [31:0] seq [4];
    seq = '{32'h0, 32'h4, 32'h8, 32'h0};
    n = 0;
    req_valid_i = 1;
    for (int i = 0; i < 6; i++) begin
      if (req_ready_o) begin
        req_addr_i = seq[n % 4];
        n++;
      end
      step();
    end
    req_valid_i = 0;
  endtask
  initial begin
    #2;
    check("rst.ready", req_ready_o, 0);
    check("rst.valid", rsp_valid_o, 0);
    check("rst.data", rsp_data_o, 32'h13);
    check("rst.err", rsp_err_o, 0);
    check("rst.addr", rsp_addr_o, 0);
    #5 rst_n_i = 1;
    wr(32'h0, 32'h0050_0093);
    wr(32'h4, 32'h0010_8113);
    wr(32'h8, 32'hAAAA_AAAA);
    wr(32'h1000, 32'hDEAD_BEEF);
    rsp_ready_i = 1;
    check("idle.ready", req_ready_o, 1);
    req_valid_i = 1;
    req_addr_i = 32'h0;
    step();
    req_addr_i = 32'h4;
    step();
    req_valid_i = 0;
    check("stream.lat", rsp_valid_o, 0);
    step();
    check_head("stream0", 32'h0050_0093, 32'h0, 0);
    step();
    check_head("stream1", 32'h0010_8113, 32'h4, 0);
    step();
    check("stream.drain", rsp_valid_o, 0);
    rsp_ready_i = 0;
    fill(acc);
    check("full.accepts", acc, 4);
    check("full.ready", req_ready_o, 0);
    check_head("full.head", 32'h0050_0093, 32'h0, 0);
    step(2);
    check_head("full.hold", 32'h0050_0093, 32'h0, 0);
    rsp_ready_i = 1;
    check("full.no_passthru", req_ready_o, 0);
    step();
    rsp_ready_i = 0;
    check("full.ready_back", req_ready_o, 1);
    check_head("full.pop1", 32'h0010_8113, 32'h4, 0);
    rsp_ready_i = 1;
    step();
    check_head("full.pop2", 32'hAAAA_AAAA, 32'h8, 0);
    step();
    check_head("full.pop3", 32'h0050_0093, 32'h0, 0);
    step();
    check("full.drain", rsp_valid_o, 0);
    rsp_ready_i = 0;
    req_valid_i = 1;
    req_addr_i = 32'h2;
    step();
    req_addr_i = 32'h1000;
    step();
    req_valid_i = 0;
    step(2);
    check_head("err.misalign", 32'h13, 32'h2, 1);
    rsp_ready_i = 1;
    step();
    check_head("err.range", 32'h13, 32'h1000, 1);
    step();
    check("err.drain", rsp_valid_o, 0);
    req_valid_i = 1;
    req_addr_i = 32'h0;
    step();
    req_addr_i = 32'h4;
    step();
    req_addr_i = 32'h8;
    step();
    req_valid_i = 0;
    flush_i = 1;
    #1;
    check("flush.valid", rsp_valid_o, 0);
    check("flush.ready", req_ready_o, 0);
    step();
    flush_i = 0;
    #1;
    check("flush.ready_after", req_ready_o, 1);
    check("flush.gone0", rsp_valid_o, 0);
    req_valid_i = 1;
    req_addr_i = 32'h4;
    step();
    req_valid_i = 0;
    check("flush.gone1", rsp_valid_o, 0);
    step();
    check("flush.gone2", rsp_valid_o, 0);
    step();
    check_head("flush.new", 32'h0010_8113, 32'h4, 0);
    step();
    check("flush.drain", rsp_valid_o, 0);
    req_valid_i = 1;
    req_addr_i = 32'h8;
    wr_en_i = 1;
    wr_addr_i = 32'h8;
    wr_data_i = 32'hBBBB_BBBB;
    step();
    wr_en_i = 0;
    step();
    req_valid_i = 0;
    step();
    check_head("rbw.old", 32'hAAAA_AAAA, 32'h8, 0);
    step();
    check_head("rbw.new", 32'hBBBB_BBBB, 32'h8, 0);
    step();
    check("rbw.drain", rsp_valid_o, 0);
    rsp_ready_i = 0;
    req_valid_i = 1;
    req_addr_i = 32'h0;
    step();
    req_addr_i = 32'h4;
    step();
    req_valid_i = 0;
    step(2);
    check_head("arst.queued", 32'h0050_0093, 32'h0, 0);
    #2 rst_n_i = 0;
    #1;
    check("arst.valid", rsp_valid_o, 0);
    check("arst.ready", req_ready_o, 0);
    check("arst.data", rsp_data_o, 32'h13);
    #1 rst_n_i = 1;
    #1;
    check("arst.ready_after", req_ready_o, 1);
    check("arst.valid_after", rsp_valid_o, 0);
    fill(acc);
    check("arst.accepts", acc, 4);
    check_head("arst.ram_kept", 32'h0050_0093, 32'h0, 0);
    rsp_ready_i = 1;
    step();
    check_head("arst.ram_kept4", 32'h0010_8113, 32'h4, 0);
    step(3);
    check("arst.drain", rsp_valid_o, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
